freq_avg: RTL and testbench
===========================

FREQ_AVG -- requirements
Module: freq_avg

Interface
REQ-001 SHALL have parameter LOCK_TOL, default 4: maximum |sample - avg| (in counts) that counts as in-tolerance.
REQ-002 SHALL have parameter LOCK_CNT, default 8: number of consecutive in-tolerance samples required to assert locked.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RESETn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous flush of window and lock state.
REQ-006 SHALL have port valid_in  input  1  one-cycle strobe qualifying counter_result from the upstream frequency estimator.
REQ-007 SHALL have port counter_result  input  10  unsigned per-window count from the frequency estimator.
REQ-008 SHALL have port avg_out  output  10  registered 4-sample moving average.
REQ-009 SHALL have port avg_valid  output  1  one-cycle strobe marking an updated avg_out.
REQ-010 SHALL have port locked  output  1  level: frequency estimate is stable.

Function
REQ-011 SHALL hold a 4-entry shift window of 10-bit samples plus a 12-bit running sum; each accepted sample enters the window and the oldest leaves.
REQ-012 SHALL accept a sample on any cycle with valid_in=1 and clear=0; back-to-back valid_in on consecutive cycles SHALL all be accepted.
REQ-013 SHALL use a state machine with states EMPTY, FILL, TRACK, LOCKED.
REQ-014 SHALL move EMPTY->FILL on the first accepted sample; stay in FILL until 4 samples are held; move FILL->TRACK on the 4th sample.
REQ-015 SHALL, on every accepted sample that leaves 4 samples in the window (4th sample onward), set avg_out = sum>>2 (truncating) and pulse avg_valid exactly one cycle, in the cycle after valid_in.
REQ-016 SHALL keep avg_valid=0 and avg_out unchanged in EMPTY and FILL.
REQ-017 SHALL, in TRACK and LOCKED, compute deviation |counter_result - avg_out| against the avg_out held before the update, using 11-bit signed arithmetic.
REQ-018 SHALL increment a lock counter on each in-tolerance sample (deviation <= LOCK_TOL), saturating at LOCK_CNT, and reset it to 0 on each out-of-tolerance sample.
REQ-019 SHALL move TRACK->LOCKED when the lock counter reaches LOCK_CNT; locked SHALL be 1 exactly while in LOCKED, registered, asserting the cycle after the qualifying sample.
REQ-020 SHALL move LOCKED->TRACK on an out-of-tolerance sample; locked deasserts the following cycle, and the window still absorbs that sample.
REQ-021 SHALL never overflow: sum is 12 bits, max 4*1023 = 4092.
REQ-022 SHALL, on clear=1, zero window, sum, lock counter, avg_out, avg_valid and locked and enter EMPTY next cycle; clear with simultaneous valid_in SHALL drop that sample.
REQ-023 SHALL ignore counter_result when valid_in=0.

Reset
REQ-024 SHALL, while RESETn=0, asynchronously force state EMPTY and window, sum, lock counter, avg_out=0, avg_valid=0, locked=0.
REQ-025 SHALL, on RESETn assertion mid-operation, including during an avg_valid pulse, discard all history; the first avg_valid after release SHALL require 4 new samples.

Verification
REQ-026 SHALL cover reset: RESETn=0 with random valid_in traffic -> avg_out=0, avg_valid=0, locked=0 throughout.
REQ-027 SHALL cover fill: samples 100,104,96,101 -> no avg_valid on first three; single avg_valid after 4th with avg_out=100.
REQ-028 SHALL cover lock: after fill, eight samples of 100 back-to-back -> locked=1 the cycle after the 8th, not earlier; avg_out=100.
REQ-029 SHALL cover unlock: from LOCKED, sample 120 (deviation 20) -> locked=0 next cycle, avg_out=105, and another 8 in-tolerance samples required to relock.
REQ-030 SHALL cover clear collision: clear=1 with valid_in=1, counter_result=500 -> all outputs 0 next cycle; next 3 samples produce no avg_valid.
REQ-031 SHALL cover range limits: four samples of 1023 -> avg_out=1023, no wrap; then 0 -> deviation 1023, lock counter 0, avg_out=767.

Source files
------------

// File: rtl/freq_avg.sv
// -----------------------------------------------------------------------------
// freq_avg
//
// Smooths the per-window counts of an upstream frequency estimator with a
// 4-sample moving average and reports when the estimate has settled.
//
// Every accepted sample enters a 4-deep window and the oldest sample leaves it.
// Once the window holds four samples, each new sample produces a fresh average
// (sum >> 2, truncating) and a one-cycle avg_valid strobe. Each new sample is
// also compared against the average published before it arrived. LOCK_CNT
// consecutive samples within LOCK_TOL counts of that average raise locked.
// A single outlier drops locked and restarts the count.
//
// Parameters
//   LOCK_TOL        largest |sample - avg| treated as in-tolerance
//   LOCK_CNT        consecutive in-tolerance samples needed for lock
//
// Ports
//   clk             rising-edge clock
//   RESETn          asynchronous active-low reset
//   clear           synchronous flush of window and lock state (drops a
//                   coincident sample)
//   valid_in        one-cycle strobe qualifying counter_result
//   counter_result  10-bit unsigned per-window count
//   avg_out         registered moving average
//   avg_valid       one-cycle strobe when avg_out has been updated
//   locked          high while the estimate is stable
// -----------------------------------------------------------------------------
module freq_avg #(
    parameter int LOCK_TOL = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       clear,
    input  logic       valid_in,
    input  logic [9:0] counter_result,
    output logic [9:0] avg_out,
    output logic       avg_valid,
    output logic       locked
);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        TRACK,
        LOCKED
    } state_t;

    localparam int               LCW          = $clog2(LOCK_CNT + 1);
    localparam logic [LCW-1:0]   LOCK_CNT_MAX = LCW'(LOCK_CNT);
    localparam logic [10:0]      LOCK_TOL_W   = 11'(LOCK_TOL);

    state_t            state;
    state_t            state_nxt;
    logic [9:0]        window [4];
    logic [11:0]       sum;
    logic [11:0]       sum_nxt;
    logic [1:0]        fill_cnt;
    logic [LCW-1:0]    lock_cnt;
    logic [LCW-1:0]    lock_cnt_nxt;

    logic              accept;
    logic              tracking;
    logic              full_after;
    logic signed [10:0] dev;
    logic [10:0]       dev_mag;
    logic              in_tol;

    // Slots that have not been filled yet hold zero, so the same
    // add-new/subtract-oldest update is correct during fill as well.
    assign sum_nxt = sum + {2'b00, counter_result} - {2'b00, window[3]};

    assign accept   = valid_in && !clear;
    assign tracking = (state == TRACK) || (state == LOCKED);

    // The sample arriving now completes (or keeps) a full window.
    assign full_after = tracking || ((state == FILL) && (fill_cnt == 2'd3));

    // Deviation uses the average published before this sample's update.
    // Both operands fit in 10 unsigned bits, so 11-bit signed cannot overflow.
    assign dev     = $signed({1'b0, counter_result}) - $signed({1'b0, avg_out});
    assign dev_mag = dev[10] ? $unsigned(-dev) : $unsigned(dev);
    assign in_tol  = (dev_mag <= LOCK_TOL_W);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state    <= EMPTY;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and lock-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;

        if (clear) begin
            state_nxt    = EMPTY;
            lock_cnt_nxt = '0;
        end else if (valid_in) begin
            unique case (state)
                EMPTY: state_nxt = FILL;
                FILL: begin
                    if (fill_cnt == 2'd3) begin
                        state_nxt = TRACK;
                    end
                end
                TRACK, LOCKED: begin
                    if (in_tol) begin
                        lock_cnt_nxt = (lock_cnt == LOCK_CNT_MAX)
                                     ? LOCK_CNT_MAX
                                     : lock_cnt + LCW'(1);
                        if (lock_cnt_nxt == LOCK_CNT_MAX) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        lock_cnt_nxt = '0;
                        state_nxt    = TRACK;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window, running sum and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            // NOTE: the window is reset too, not just the sum; the
            // subtract-oldest update relies on empty slots reading zero.
            for (int i = 0; i < 4; i++) begin
                window[i] <= '0;
            end
            sum       <= '0;
            fill_cnt  <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            locked    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) begin
                window[i] <= '0;
            end
            sum       <= '0;
            fill_cnt  <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            locked    <= (state_nxt == LOCKED);
            if (accept) begin
                window[0] <= counter_result;
                for (int i = 1; i < 4; i++) begin
                    window[i] <= window[i-1];
                end
                sum <= sum_nxt;
                // Counts 0..3 during fill and wraps to 0 on the 4th sample;
                // it is not consulted once tracking.
                if (!tracking) begin
                    fill_cnt <= fill_cnt + 2'd1;
                end
                if (full_after) begin
                    avg_out   <= sum_nxt[11:2];
                    avg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_avg.sv
// -----------------------------------------------------------------------------
// tb_freq_avg
//
// Self-checking bench for freq_avg. Stimulus updates a reference model (a
// queue of the last four samples plus a lock count) and pushes each expected
// average into a scoreboard queue; a monitor on the falling edge pops an
// entry whenever avg_valid is seen and also checks avg_out hold and locked.
// -----------------------------------------------------------------------------
module tb_freq_avg;

    localparam int LOCK_TOL = 4;
    localparam int LOCK_CNT = 8;

    logic       clk = 1'b0;
    logic       RESETn = 1'b0;
    logic       clear = 1'b0;
    logic       valid_in = 1'b0;
    logic [9:0] counter_result = '0;
    logic [9:0] avg_out;
    logic       avg_valid;
    logic       locked;

    freq_avg #(
        .LOCK_TOL(LOCK_TOL),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk           (clk),
        .RESETn        (RESETn),
        .clear         (clear),
        .valid_in      (valid_in),
        .counter_result(counter_result),
        .avg_out       (avg_out),
        .avg_valid     (avg_valid),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int win[$];
    int lock_c  = 0;
    int mavg    = 0;
    bit mlocked = 1'b0;
    int exp_q[$];

    // Expected steady-state outputs after the most recent rising edge
    int exp_hold   = 0;
    bit exp_locked = 1'b0;
    bit mon_en     = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        win.delete();
        lock_c  = 0;
        mavg    = 0;
        mlocked = 1'b0;
    endtask

    task automatic model_sample(input int s);
        int total;
        int d;
        if (win.size() == 4) begin
            d = s - mavg;
            if (d < 0) d = -d;
            if (d <= LOCK_TOL) lock_c = (lock_c < LOCK_CNT) ? lock_c + 1 : LOCK_CNT;
            else               lock_c = 0;
        end
        win.push_front(s);
        if (win.size() > 4) void'(win.pop_back());
        if (win.size() == 4) begin
            total = 0;
            foreach (win[i]) total += win[i];
            mavg = total / 4;
            exp_q.push_back(mavg);
        end
        mlocked = (lock_c == LOCK_CNT);
    endtask

    // One clock of stimulus; returns #1 after the rising edge so the
    // registered response to this cycle is visible.
    task automatic step(input bit clr, input bit vin, input int data);
        clear          = clr;
        valid_in       = vin;
        counter_result = 10'(data);
        if (clr)      model_clear();
        else if (vin) model_sample(data);
        @(posedge clk);
        #1;
        exp_locked = mlocked;
        exp_hold   = mavg;
        clear      = 1'b0;
        valid_in   = 1'b0;
    endtask

    // Monitor: decoupled from stimulus, pops the scoreboard on avg_valid.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (avg_valid) begin
                    if (exp_q.size() == 0) begin
                        check("avg_valid_unexpected", avg_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("avg_out", avg_out, e);
                    end
                end else begin
                    check("avg_hold", avg_out, exp_hold);
                end
                check("locked", locked, exp_locked);
            end
        end
    end

    initial begin
        // Reset held with random traffic: outputs must stay zero.
        RESETn = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            valid_in       = 1'($urandom_range(0, 1));
            counter_result = 10'($urandom_range(0, 1023));
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        RESETn   = 1'b1;
        model_clear();
        step(0, 0, 0);

        // Fill: no strobe on first three, average 100 after the fourth.
        step(0, 1, 100); check("fill_valid_1", avg_valid, 0);
        step(0, 1, 104); check("fill_valid_2", avg_valid, 0);
        step(0, 1, 96);  check("fill_valid_3", avg_valid, 0);
        step(0, 1, 101); check("fill_valid_4", avg_valid, 1);
        check("fill_avg", avg_out, 100);

        // Lock after exactly eight in-tolerance samples.
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(0, 1, 100);
            check("lock_level", locked, (i == LOCK_CNT - 1) ? 1 : 0);
        end
        check("lock_avg", avg_out, 100);

        // Unlock on a 20-count outlier; another eight needed to relock.
        step(0, 1, 120);
        check("unlock_level", locked, 0);
        check("unlock_avg", avg_out, 105);
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(0, 1, 105);
            check("relock_level", locked, (i == LOCK_CNT - 1) ? 1 : 0);
        end

        // Clear colliding with a sample: sample dropped, outputs zeroed.
        step(1, 1, 500);
        check("clear_avg", avg_out, 0);
        check("clear_valid", avg_valid, 0);
        check("clear_locked", locked, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 200);
            check("post_clear_valid", avg_valid, 0);
        end
        step(0, 1, 200);
        check("post_clear_4th", avg_valid, 1);
        check("post_clear_avg", avg_out, 200);

        // Range limits: full-scale samples, then a full-scale drop.
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1023);
        check("max_avg", avg_out, 1023);
        step(0, 1, 0);
        check("drop_avg", avg_out, 767);
        check("drop_locked", locked, 0);

        // Randomised traffic around drifting centre values.
        begin
            int base = 500;
            int d;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 99) < 3) base = $urandom_range(10, 1000);
                if ($urandom_range(0, 99) < 5) d = $urandom_range(0, 1023);
                else                           d = base + $urandom_range(0, 6) - 3;
                if ($urandom_range(0, 99) < 2)
                    step(1, 1'($urandom_range(0, 1)), d);
                else
                    step(0, 1'($urandom_range(0, 99) < 70), d);
            end
        end

        // Reset asserted during an avg_valid pulse discards all history.
        for (int i = 0; i < 4; i++) step(0, 1, 300 + i);
        check("pre_reset_pulse", avg_valid, 1);
        RESETn = 1'b0;
        exp_q.delete();
        model_clear();
        exp_hold   = 0;
        exp_locked = 1'b0;
        #1;
        check("reset_kills_pulse", avg_valid, 0);
        check("reset_avg", avg_out, 0);
        @(posedge clk);
        #1;
        RESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 700);
            check("post_reset_valid", avg_valid, 0);
        end
        step(0, 1, 704);
        check("post_reset_4th", avg_valid, 1);
        check("post_reset_avg", avg_out, 701);

        step(0, 0, 0);
        step(0, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
